// File: rtl/xfer_scheduler_pkg.sv
// xfer_scheduler_pkg: shared state encoding and size defaults for the transfer scheduler
package xfer_scheduler_pkg;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_LEN_W  = 5;
   localparam int MAX_LEN    = 16;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin pick; on a tie the side not granted last wins
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/xfer_scheduler.sv
// xfer_scheduler: arbitrates two requesters and copies memory A to memory B word by word,
// writing each read word one cycle later once the read data has returned.
module xfer_scheduler
   import xfer_scheduler_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              Req1,
   input  logic [ADDR_W-1:0] SrcBase0,
   input  logic [ADDR_W-1:0] SrcBase1,
   input  logic [ADDR_W-1:0] DstBase0,
   input  logic [ADDR_W-1:0] DstBase1,
   input  logic [LEN_W-1:0]  Len0,
   input  logic [LEN_W-1:0]  Len1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              Done0,
   output logic              Done1,
   output logic              Busy,
   output logic              REA,
   output logic [ADDR_W-1:0] AddrA,
   output logic              WEB,
   output logic [ADDR_W-1:0] AddrB
);
   state_e              state_q, state_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d, len_q, len_d, len_in;
   logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, addra_q, addra_d, addrb_q, addrb_d;
   logic                last_q, last_d, rea_q, rea_d, web_q, web_d, busy_q;
   logic [1:0]          gnt_q, gnt_d, done_q, done_d, arb_gnt;

   rr_arb2 u_arb (.req({Req1, Req0}), .last(last_q), .gnt(arb_gnt));

   assign len_in = arb_gnt[1] ? Len1 : Len0;

   // Outputs are next-cycle values registered at the edge, so each register holds what its cycle needs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      src_d   = src_q;
      dst_d   = dst_q;
      last_d  = last_q;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      rea_d   = 1'b0;
      web_d   = 1'b0;
      addra_d = addra_q;
      addrb_d = addrb_q;
      case (state_q)
         IDLE: if (|arb_gnt) begin
            last_d = arb_gnt[1];
            src_d  = arb_gnt[1] ? SrcBase1 : SrcBase0;
            dst_d  = arb_gnt[1] ? DstBase1 : DstBase0;
            len_d  = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
            cnt_d  = '0;
            gnt_d  = arb_gnt;
            if (len_d == '0) begin
               state_d = DONE;
               done_d  = arb_gnt;
            end else begin
               state_d = READ;
               rea_d   = 1'b1;
               addra_d = src_d;
            end
         end
         READ: begin
            web_d   = 1'b1;
            addrb_d = dst_q + ADDR_W'(cnt_q);
            if (cnt_q + LEN_W'(1) < len_q) begin
               cnt_d   = cnt_q + LEN_W'(1);
               rea_d   = 1'b1;
               addra_d = src_q + ADDR_W'(cnt_d);
            end else state_d = DRAIN;
         end
         DRAIN: begin
            state_d = DONE;
            done_d  = last_q ? 2'b10 : 2'b01;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         last_q  <= 1'b1;
         gnt_q   <= '0;
         done_q  <= '0;
         rea_q   <= 1'b0;
         web_q   <= 1'b0;
         busy_q  <= 1'b0;
         addra_q <= '0;
         addrb_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         rea_q   <= rea_d;
         web_q   <= web_d;
         busy_q  <= (state_d != IDLE);
         addra_q <= addra_d;
         addrb_q <= addrb_d;
      end
   end

   assign {Gnt1, Gnt0}   = gnt_q;
   assign {Done1, Done0} = done_q;
   assign Busy  = busy_q;
   assign REA   = rea_q;
   assign WEB   = web_q;
   assign AddrA = addra_q;
   assign AddrB = addrb_q;
endmodule
